posit_unpack_pipe: RTL and testbench



---
 rtl/posit_pkg.sv | 21 ++
 rtl/posit_unpack_pipe_if.sv | 34 +++
 rtl/posit_regime_cnt.sv | 28 ++
 rtl/posit_unpack_pipe.sv | 131 +++++++++++++
 tb/tb_posit_unpack_pipe.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/posit_pkg.sv
// Shared posit widths, the NaR pattern and the unpacked-field record
// produced by posit_unpack_pipe and consumed by the multiplier datapath.
package posit_pkg;

  localparam int POSIT_N  = 32;
  localparam int POSIT_ES = 2;
  localparam int POSIT_RS = $clog2(POSIT_N);

  localparam logic [POSIT_N-1:0] POSIT_NAR = {1'b1, {(POSIT_N-1){1'b0}}};

  typedef struct packed {
    logic                                sign;
    logic signed [POSIT_RS:0]            k;
    logic [POSIT_ES-1:0]                 exp;
    logic [POSIT_N-1:0]                  mant;
    logic signed [POSIT_RS+POSIT_ES+1:0] scale;
    logic                                zero;
    logic                                inf;
  } posit_unpacked_t;

endpackage

// File: rtl/posit_unpack_pipe_if.sv
// Input word and unpacked-result channels of posit_unpack_pipe.
// Both channels use valid/ready: a transfer happens on a clock edge where valid & ready are both high.
interface posit_unpack_pipe_if
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES,
  parameter int RS = $clog2(N)
);

  logic                    in_valid;
  logic                    in_ready;
  logic [N-1:0]            in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_sign;
  logic signed [RS:0]      out_k;
  logic [ES-1:0]           out_exp;
  logic [N-1:0]            out_mant;
  logic signed [RS+ES+1:0] out_scale;
  logic                    out_zero;
  logic                    out_inf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_k, out_exp, out_mant, out_scale, out_zero, out_inf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_k, out_exp, out_mant, out_scale, out_zero, out_inf
  );

endinterface

// File: rtl/posit_regime_cnt.sv
// Leading-run counter for the posit regime: run length m of bits equal to the MSB,
// and how far to shift left to drop the regime plus its terminating bit.
module posit_regime_cnt #(
  parameter int W  = 31,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits_i,
  output logic          r0_o,
  output logic [CW-1:0] m_o,
  output logic [CW-1:0] shift_o
);

  logic run;

  always_comb begin
    run = 1'b1;
    m_o = CW'(1);
    for (int i = W - 2; i >= 0; i--) begin
      if (run && (bits_i[i] == bits_i[W-1])) m_o = m_o + CW'(1);
      else run = 1'b0;
    end
  end

  assign r0_o = bits_i[W-1];
  // A run reaching the LSB has no terminator to skip.
  assign shift_o = (m_o == CW'(W)) ? m_o : m_o + CW'(1);

endmodule

// File: rtl/posit_unpack_pipe.sv
// Two-stage posit decoder: capture sign/abs/special flags, then decode regime, exponent and fraction.
// Build option POSIT_UNPACK_SKID_EN adds a 2-entry skid buffer so in_ready comes straight from a flop.
module posit_unpack_pipe
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES,
  parameter int RS = POSIT_RS
) (
  input logic               clk,
  input logic               rst,
  posit_unpack_pipe_if.slave bus
);

  // The stage-2 record uses the package widths, so N/ES/RS must keep their defaults.
  logic            s1_valid_q, s1_sign_q, s1_zero_q, s1_inf_q;
  logic [N-2:0]    s1_abs_q;
  logic            s2_valid_q;
  posit_unpacked_t s2_q, s2_d;

  logic            s1_adv, s1_take, src_valid;
  logic [N-1:0]    src_data;

  assign s1_adv  = ~s2_valid_q | bus.out_ready;
  assign s1_take = ~s1_valid_q | s1_adv;

`ifdef POSIT_UNPACK_SKID_EN
  logic [N-1:0] skid_mem_q [2];
  logic         skid_wr_q, skid_rd_q, ready_q, push, pop;
  logic [1:0]   skid_cnt_q, skid_cnt_d;

  assign push       = bus.in_valid & ready_q;
  assign src_valid  = (skid_cnt_q != 2'd0);
  assign pop        = src_valid & s1_take;
  assign src_data   = skid_mem_q[skid_rd_q];
  assign skid_cnt_d = skid_cnt_q + {1'b0, push} - {1'b0, pop};
  assign bus.in_ready = ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_wr_q  <= 1'b0;
      skid_rd_q  <= 1'b0;
      skid_cnt_q <= 2'd0;
      ready_q    <= 1'b1;
    end else begin
      if (push) skid_wr_q <= ~skid_wr_q;
      if (pop)  skid_rd_q <= ~skid_rd_q;
      skid_cnt_q <= skid_cnt_d;
      ready_q    <= (skid_cnt_d != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (push) skid_mem_q[skid_wr_q] <= bus.in_data;
  end
`else
  assign src_valid    = bus.in_valid;
  assign src_data     = bus.in_data;
  assign bus.in_ready = s1_take;
`endif

  // Only the low N-1 bits of |x| are needed; they depend only on the low bits of x.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_abs_q   <= '0;
      s1_zero_q  <= 1'b0;
      s1_inf_q   <= 1'b0;
    end else if (s1_take) begin
      s1_valid_q <= src_valid;
      if (src_valid) begin
        s1_sign_q <= src_data[N-1];
        s1_abs_q  <= src_data[N-1] ? -src_data[N-2:0] : src_data[N-2:0];
        s1_zero_q <= (src_data == '0);
        s1_inf_q  <= (src_data == POSIT_NAR);
      end
    end
  end

  logic          r0;
  logic [RS-1:0] m, shamt;
  logic [N-2:0]  rem;
  logic [RS:0]   k_raw;

  posit_regime_cnt #(.W(N - 1), .CW(RS)) u_regime_cnt (
    .bits_i (s1_abs_q),
    .r0_o   (r0),
    .m_o    (m),
    .shift_o(shamt)
  );

  assign rem   = s1_abs_q << shamt;
  assign k_raw = r0 ? ({1'b0, m} - (RS + 1)'(1)) : -{1'b0, m};

  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_sign_q;
    s2_d.zero = s1_zero_q;
    s2_d.inf  = s1_inf_q;
    if (s1_zero_q | s1_inf_q) begin
      s2_d.mant = {s1_inf_q, {(N-1){1'b0}}};
    end else begin
      s2_d.k     = k_raw;
      s2_d.exp   = rem[N-2 -: ES];
      s2_d.mant  = {1'b1, rem[N-2-ES:0], {ES{1'b0}}};
      // k <<< ES leaves the low ES bits clear, so adding exp is a concatenation.
      s2_d.scale = {k_raw[RS], k_raw, rem[N-2 -: ES]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else if (s1_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) s2_q <= s2_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_sign  = s2_q.sign;
  assign bus.out_k     = s2_q.k;
  assign bus.out_exp   = s2_q.exp;
  assign bus.out_mant  = s2_q.mant;
  assign bus.out_scale = s2_q.scale;
  assign bus.out_zero  = s2_q.zero;
  assign bus.out_inf   = s2_q.inf;

endmodule

// File: tb/tb_posit_unpack_pipe.sv
// Directed bench for posit_unpack_pipe: field decode vectors, streaming, stall and mid-stream reset.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_posit_unpack_pipe;
  import posit_pkg::*;

`ifdef POSIT_UNPACK_SKID_EN
  localparam int LAT       = 3;
  localparam int STALL_ACC = 4;
`else
  localparam int LAT       = 2;
  localparam int STALL_ACC = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  posit_unpack_pipe_if #(.N(32), .ES(2), .RS(5)) bus_if ();

  posit_unpack_pipe dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_out;
  int          cyc_cnt = 0;
  int          out_cyc[$];
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: drive this cycle's inputs, then score any result that will be consumed.
  task automatic step(input logic rdy, input logic vld, input logic [31:0] d, output logic acc);
    @(negedge clk);
    bus_if.out_ready = rdy;
    bus_if.in_valid  = vld;
    bus_if.in_data   = d;
    #1;
    acc = vld & bus_if.in_ready;
    if (bus_if.out_valid && rdy) begin
      n_out++;
      out_cyc.push_back(cyc_cnt);
      if (exp_q.size() == 0) chk("out_expected", 64'(exp_q.size() != 0), 64'd1);
      else chk("stream_mant", bus_if.out_mant, exp_q.pop_front());
    end
  endtask

  task automatic single(input logic [31:0] d, input logic e_sign, input int e_k,
                        input logic [1:0] e_exp, input logic [31:0] e_mant, input int e_scale,
                        input logic e_zero, input logic e_inf);
    logic acc;
    step(1'b1, 1'b1, d, acc);
    chk($sformatf("%h.accept", d), acc, 1);
    for (int i = 1; i < LAT; i++) begin
      step(1'b1, 1'b0, 32'h0, acc);
      chk($sformatf("%h.early_valid", d), bus_if.out_valid, 0);
    end
    @(negedge clk);
    #1;
    chk($sformatf("%h.valid", d), bus_if.out_valid, 1);
    chk($sformatf("%h.sign", d),  bus_if.out_sign, e_sign);
    chk($sformatf("%h.k", d),     int'(bus_if.out_k), e_k);
    chk($sformatf("%h.exp", d),   bus_if.out_exp, e_exp);
    chk($sformatf("%h.mant", d),  bus_if.out_mant, e_mant);
    chk($sformatf("%h.scale", d), int'(bus_if.out_scale), e_scale);
    chk($sformatf("%h.zero", d),  bus_if.out_zero, e_zero);
    chk($sformatf("%h.inf", d),   bus_if.out_inf, e_inf);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   idx, acc_stall;
    logic held_valid;
    logic [31:0] held;

    rst = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.valid", bus_if.out_valid, 0);
    chk("rst.mant",  bus_if.out_mant, 0);
    chk("rst.k",     int'(bus_if.out_k), 0);
    chk("rst.scale", int'(bus_if.out_scale), 0);
    chk("rst.flags", {bus_if.out_sign, bus_if.out_zero, bus_if.out_inf}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst.in_ready", bus_if.in_ready, 1);

    // Decode vectors
    single(32'h40000000, 1'b0,   0, 2'd0, 32'h80000000,    0, 1'b0, 1'b0);
    single(32'h48000000, 1'b0,   0, 2'd1, 32'h80000000,    1, 1'b0, 1'b0);
    single(32'h60000000, 1'b0,   1, 2'd0, 32'h80000000,    4, 1'b0, 1'b0);
    single(32'hC0000000, 1'b1,   0, 2'd0, 32'h80000000,    0, 1'b0, 1'b0);
    single(32'h00000000, 1'b0,   0, 2'd0, 32'h00000000,    0, 1'b1, 1'b0);
    single(32'h80000000, 1'b1,   0, 2'd0, 32'h80000000,    0, 1'b0, 1'b1);
    single(32'h7FFFFFFF, 1'b0,  30, 2'd0, 32'h80000000,  120, 1'b0, 1'b0);
    single(32'h00000001, 1'b0, -30, 2'd0, 32'h80000000, -120, 1'b0, 1'b0);
    single(32'h40000001, 1'b0,   0, 2'd0, 32'h80000010,    0, 1'b0, 1'b0);
    single(32'hB0000000, 1'b1,   0, 2'd2, 32'h80000000,    2, 1'b0, 1'b0);
    single(32'h3C000000, 1'b0,  -1, 2'd3, 32'hC0000000,   -1, 1'b0, 1'b0);

    // Back-to-back stream of 8 words
    n_out = 0;
    out_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(32'h80000000 | (32'(i) << 12));
      step(1'b1, 1'b1, 32'h40000000 | (32'(i) << 8), acc);
      chk("stream.accept", acc, 1);
    end
    for (int t = 0; t < 20 && n_out < 8; t++) step(1'b1, 1'b0, 32'h0, acc);
    chk("stream.count", n_out, 8);
    if (out_cyc.size() == 8) chk("stream.no_bubble", out_cyc[7] - out_cyc[0], 7);

    // Stall for 5 cycles while offering words
    n_out = 0;
    idx = 0;
    acc_stall = 0;
    held_valid = 1'b0;
    held = '0;
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b1, 32'h40000000 | (32'(idx + 8) << 8), acc);
      if (acc) begin
        exp_q.push_back(32'h80000000 | (32'(idx + 8) << 12));
        idx++;
        acc_stall++;
      end
      if (bus_if.out_valid) begin
        if (held_valid) chk("stall.hold", bus_if.out_mant, held);
        else begin
          held = bus_if.out_mant;
          held_valid = 1'b1;
        end
      end
    end
    chk("stall.accepts", acc_stall, STALL_ACC);
    chk("stall.in_ready", bus_if.in_ready, 0);
    chk("stall.head", held, 32'h80000000 | (32'd8 << 12));
    for (int t = 0; t < 40 && n_out < 8; t++) begin
      step(1'b1, idx < 8, 32'h40000000 | (32'(idx + 8) << 8), acc);
      if (acc) begin
        exp_q.push_back(32'h80000000 | (32'(idx + 8) << 12));
        idx++;
      end
    end
    chk("stall.count", n_out, 8);
    chk("stall.q_empty", exp_q.size(), 0);

    // Reset with the pipeline full
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 32'hC0000000, acc);
    @(negedge clk);
    rst = 1'b1;
    bus_if.in_valid = 1'b0;
    #1;
    chk("midrst.valid", bus_if.out_valid, 0);
    chk("midrst.mant",  bus_if.out_mant, 0);
    chk("midrst.sign",  bus_if.out_sign, 0);
    chk("midrst.k",     int'(bus_if.out_k), 0);
    chk("midrst.scale", int'(bus_if.out_scale), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0, 32'h0, acc);
      chk("midrst.quiet", bus_if.out_valid, 0);
    end
    single(32'h60000000, 1'b0, 1, 2'd0, 32'h80000000, 4, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
